word_serializer: RTL and testbench
==================================

WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter W, default 8: input word width in bits; legal range 1 to 64.
REQ-002 SHALL have parameter ID, default 0: instance tag; no functional effect.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream word is present.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
REQ-007 SHALL have port in_data, input, W bits: parallel word; bit 0 is the LSB.
REQ-008 SHALL have port out_valid, output, 1 bit: out_bit is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream takes the current bit.
REQ-010 SHALL have port out_bit, output, 1 bit: current serial bit.
REQ-011 SHALL have port out_last, output, 1 bit: current bit is the final beat of the frame.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-013 SHALL implement exactly two states: IDLE and SHIFT.
REQ-014 SHALL define N, the beats per frame, as W; with parity enabled, N SHALL be W+1.
REQ-015 SHALL drive in_ready=1 in IDLE, and in SHIFT only during the final-beat handshake (out_valid && out_ready && out_last).
REQ-016 SHALL treat in_valid && in_ready as acceptance: capture in_data into the shift register, clear the beat counter, and enter or stay in SHIFT.
REQ-017 SHALL assert out_valid in the cycle after acceptance, so latency from acceptance to the first bit is 1 cycle.
REQ-018 SHALL keep out_valid=1 throughout SHIFT and out_valid=0 in IDLE.
REQ-019 SHALL output bits LSB-first: out_bit equals shift register bit 0.
REQ-020 SHALL shift right by one and increment the counter on each out_valid && out_ready beat.
REQ-021 SHALL hold out_bit, out_last and the counter stable while out_valid && !out_ready.
REQ-022 SHALL assert out_last exactly when the counter equals N-1.
REQ-023 SHALL, on the final-beat handshake with no simultaneous acceptance, return to IDLE on the next edge.
REQ-024 SHALL, on the final-beat handshake with a simultaneous acceptance, load the new word and stay in SHIFT, with no gap cycle between frames.
REQ-025 SHALL size the counter at max(1, clog2(N+1)) bits; the counter SHALL never exceed N-1.
REQ-026 SHALL, for W=1 without parity, assert out_last on every frame's single beat.
REQ-027 SHALL ignore in_data while in_ready=0; the captured word SHALL be unaffected.
REQ-028 SHALL drive busy equal to (state == SHIFT).

Reset
REQ-029 SHALL, on rst assertion, immediately force state=IDLE, counter=0, shift register=0, and the parity accumulator to 0.
REQ-030 SHALL hold out_valid=0, out_last=0, out_bit=0, busy=0 and in_ready=1 while rst=1.
REQ-031 SHALL discard any frame in progress when rst is asserted mid-frame, with no partial completion after release.
REQ-032 SHALL accept a word on the first rising edge after rst deasserts.

Configuration
REQ-033 SHALL, with macro WORD_SERIALIZER_PARITY_EN defined, append one even-parity bit (XOR of the captured W bits) as beat N-1, and out_last SHALL mark the parity beat.
REQ-034 SHALL, without WORD_SERIALIZER_PARITY_EN, emit exactly W data beats and include no parity logic.

Verification
REQ-035 SHALL cover: W=8, send 8'hA5 with out_ready=1 -> bits 1,0,1,0,0,1,0,1 on consecutive cycles, out_last on the 8th, first bit 1 cycle after acceptance.
REQ-036 SHALL cover: W=8, send 8'h3C with out_ready toggling 1,0 -> each bit held while stalled, bit sequence 0,0,1,1,1,1,0,0, out_last only on the final accepted beat.
REQ-037 SHALL cover: back-to-back 8'hFF then 8'h00 with in_valid held high -> 16 contiguous out_valid cycles, in_ready pulses on beat 8, out_last on beats 8 and 16.
REQ-038 SHALL cover: W=1, words 1,0,1 -> out_last=1 on every beat, one beat per frame.
REQ-039 SHALL cover: rst pulsed after beat 3 of 8'hF0 -> out_valid=0 immediately, busy=0, no further bits; next word 8'h01 serialized from bit 0.
REQ-040 SHALL cover: with WORD_SERIALIZER_PARITY_EN, 8'h07 -> 9 beats, 9th beat = 1 with out_last; 8'h03 -> 9th beat = 0.

Source files
------------

// File: rtl/word_serializer.sv
// word_serializer: parallel word in, LSB-first serial bits out, ready/valid on both sides.
// Define WORD_SERIALIZER_PARITY_EN to append one even-parity beat after the data bits.
module word_serializer #(
  parameter int W  = 8,
  parameter int ID = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_bit,
  output logic         out_last,
  output logic         busy
);

`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  localparam int CW_RAW = $clog2(N + 1);
  // ID is an instance tag only; the second term is always zero.
  localparam int CW = ((CW_RAW < 1) ? 1 : CW_RAW) + ((ID == ID) ? 0 : 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]    state_r;
  logic [0:0]    state_nxt_s;
  logic [N-1:0]  shreg_r;
  logic [N-1:0]  shreg_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          last_r;
  logic          last_nxt_s;
  logic [N-1:0]  load_s;
  logic          beat_s;
  logic          final_s;
  logic          accept_s;

`ifdef WORD_SERIALIZER_PARITY_EN
  function automatic logic even_parity(input logic [W-1:0] d);
    even_parity = ^d;
  endfunction

  // The parity bit rides in the top of the shift register and falls out as the last beat.
  assign load_s = {even_parity(in_data), in_data};
`else
  assign load_s = in_data;
`endif

  // Handshake decode from the current state.
  always_comb begin
    in_ready = 1'b0;
    beat_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
        beat_s   = 1'b0;
      end
      ST_SHIFT: begin
        beat_s   = out_ready;
        in_ready = out_ready && last_r;
      end
      default: begin
        in_ready = 1'b1;
        beat_s   = 1'b0;
      end
    endcase
  end

  assign final_s  = beat_s && last_r;
  assign accept_s = in_valid && in_ready;

  // Next-state: acceptance wins over the final beat so frames chain without a gap.
  always_comb begin
    state_nxt_s = state_r;
    shreg_nxt_s = shreg_r;
    cnt_nxt_s   = cnt_r;
    last_nxt_s  = last_r;
    if (accept_s) begin
      state_nxt_s = ST_SHIFT;
      shreg_nxt_s = load_s;
      cnt_nxt_s   = ZERO_CNT;
      last_nxt_s  = (LAST_CNT == ZERO_CNT);
    end else if (final_s) begin
      state_nxt_s = ST_IDLE;
      shreg_nxt_s = {N{1'b0}};
      cnt_nxt_s   = ZERO_CNT;
      last_nxt_s  = 1'b0;
    end else if (beat_s) begin
      state_nxt_s = ST_SHIFT;
      shreg_nxt_s = shreg_r >> 1;
      cnt_nxt_s   = cnt_r + CW'(1);
      last_nxt_s  = ((cnt_r + CW'(1)) == LAST_CNT);
    end else begin
      state_nxt_s = state_r;
      shreg_nxt_s = shreg_r;
      cnt_nxt_s   = cnt_r;
      last_nxt_s  = last_r;
    end
  end

  // State registers; reset drops any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      shreg_r <= {N{1'b0}};
      cnt_r   <= ZERO_CNT;
      last_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      shreg_r <= shreg_nxt_s;
      cnt_r   <= cnt_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  assign out_valid = (state_r == ST_SHIFT);
  assign busy      = (state_r == ST_SHIFT);
  assign out_bit   = shreg_r[0];
  assign out_last  = last_r;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: W=8 and W=1 instances, table of words plus hand sequences,
// every serial beat compared against a scoreboard filled at word acceptance.
module tb_word_serializer;

`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int N8 = 9;
  localparam int N1 = 2;
`else
  localparam int N8 = 8;
  localparam int N1 = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_bit, out_last, busy;
  logic [7:0] in_data;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, out_bit1, out_last1, busy1;
  logic [0:0] in_data1;

  always #5 clk = ~clk;

  word_serializer #(.W(8), .ID(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last),
    .busy(busy)
  );

  word_serializer #(.W(1), .ID(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_bit(out_bit1), .out_last(out_last1),
    .busy(busy1)
  );

  typedef struct {
    logic [7:0] data;
    logic       stall;
    logic       par;
  } vec_t;

  vec_t       vecs[8];
  logic [1:0] sb8[$];
  logic [1:0] sb1[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         beats8  = 0;
  int         beats1  = 0;
  logic       cur_par = 1'b0;
  logic       hold_pending = 1'b0;
  logic       hold_bit = 1'b0;
  logic       hold_last = 1'b0;
  logic       acc1_seen = 1'b0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Observe handshakes that will complete at the coming rising edge.
  task automatic monitor();
    logic [1:0] e;
    logic       b;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check_bit("stall_hold_valid", out_valid, 1'b1);
        check_bit("stall_hold_bit", out_bit, hold_bit);
        check_bit("stall_hold_last", out_last, hold_last);
      end
      hold_pending = out_valid && !out_ready;
      hold_bit     = out_bit;
      hold_last    = out_last;
      if (out_valid) check_bit("ready_in_shift", in_ready, out_ready && out_last);
      if (out_valid && out_ready) begin
        beats8++;
        if (sb8.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb8_unexpected_beat: got bit %b with empty queue at %0t", out_bit, $time);
        end else begin
          e = sb8.pop_front();
          check_bit("sb8_bit", out_bit, e[0]);
          check_bit("sb8_last", out_last, e[1]);
        end
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < N8; i++) begin
          b = (i < 8) ? in_data[i[2:0]] : cur_par;
          sb8.push_back({logic'(i == N8 - 1), b});
        end
      end
`ifndef WORD_SERIALIZER_PARITY_EN
      if (out_valid1) check_bit("w1_last_every_beat", out_last1, 1'b1);
`endif
      if (out_valid1 && out_ready1) begin
        beats1++;
        if (sb1.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb1_unexpected_beat: got bit %b with empty queue at %0t", out_bit1, $time);
        end else begin
          e = sb1.pop_front();
          check_bit("sb1_bit", out_bit1, e[0]);
          check_bit("sb1_last", out_last1, e[1]);
        end
      end
      if (in_valid1 && in_ready1) begin
        acc1_seen = 1'b1;
        for (int i = 0; i < N1; i++) sb1.push_back({logic'(i == N1 - 1), in_data1[0]});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic stall, input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      out_ready = stall ? ((c % 2) == 0) : 1'b1;
      tick();
      done = !out_valid;
    end
    out_ready = 1'b1;
    check_bit({name, "_idle"}, busy, 1'b0);
    check_int({name, "_sb_empty"}, sb8.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h07, 1'b0, 1'b1};
    vecs[3] = '{8'h03, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'hFE, 1'b1, 1'b1};
    vecs[7] = '{8'h00, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_out_last", out_last, 1'b0);
    check_bit("rst_out_bit", out_bit, 1'b0);
    check_bit("rst_in_ready1", in_ready1, 1'b1);
    check_bit("rst_out_valid1", out_valid1, 1'b0);
    rst = 1'b0;

    // Table: one word per entry, optionally with out_ready toggling 1,0.
    for (int v = 0; v < 8; v++) begin
      beats8   = 0;
      cur_par  = vecs[v].par;
      in_data  = vecs[v].data;
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = ~vecs[v].data;
      check_bit("latency_valid", out_valid, 1'b1);
      check_bit("first_bit", out_bit, vecs[v].data[0]);
      drain(vecs[v].stall, "vec");
      check_int("vec_beats", beats8, N8);
    end

    // Back-to-back FF then 00 with in_valid held high.
    beats8 = 0; cur_par = 1'b0; in_data = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_data = 8'h00;
    for (int k = 1; k <= 2 * N8; k++) begin
      check_bit("b2b_valid", out_valid, 1'b1);
      check_bit("b2b_in_ready", in_ready, (k == N8) || (k == 2 * N8));
      check_bit("b2b_last", out_last, (k == N8) || (k == 2 * N8));
      tick();
      if (k == N8) in_valid = 1'b0;
    end
    check_bit("b2b_end_valid", out_valid, 1'b0);
    check_int("b2b_beats", beats8, 2 * N8);
    check_int("b2b_sb_empty", sb8.size(), 0);

    // Reset mid-frame after three beats of F0.
    beats8 = 0; cur_par = 1'b0; in_data = 8'hF0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check_int("rst_pre_beats", beats8, 3);
    rst = 1'b1;
    #1;
    check_bit("midrst_valid", out_valid, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_last", out_last, 1'b0);
    check_bit("midrst_bit", out_bit, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b1);
    sb8.delete();
    tick();
    tick();
    check_bit("midrst_hold_valid", out_valid, 1'b0);
    rst = 1'b0;
    beats8 = 0; cur_par = 1'b1; in_data = 8'h01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_bit("postrst_valid", out_valid, 1'b1);
    check_bit("postrst_first_bit", out_bit, 1'b1);
    drain(1'b0, "postrst");
    check_int("postrst_beats", beats8, N8);

    // W=1 instance: words 1,0,1 with in_valid held.
    beats1 = 0; out_ready1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data1  = (i == 1) ? 1'b0 : 1'b1;
      in_valid1 = 1'b1;
      acc1_seen = 1'b0;
      for (int c = 0; c < 8 && !acc1_seen; c++) tick();
      check_bit("w1_accepted", acc1_seen, 1'b1);
    end
    in_valid1 = 1'b0;
    for (int c = 0; c < 8 && out_valid1; c++) tick();
    check_int("w1_beats", beats1, 3 * N1);
    check_bit("w1_idle", busy1, 1'b0);
    check_int("w1_sb_empty", sb1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
